// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: EX_WB record, opcodes, state encoding and ALU helper.
package pipeline_pkg;

   localparam logic [0:7] OP_ADD    = 8'h01;
   localparam logic [0:7] OP_SUB    = 8'h29;
   localparam logic [0:7] OP_AND    = 8'h21;
   localparam logic [0:7] OP_OR     = 8'h09;
   localparam logic [0:7] OP_XOR    = 8'h31;
   localparam logic [0:7] OP_ALUIMM = 8'h81;
   localparam logic [0:7] OP_STORE  = 8'h89;
   localparam logic [0:7] OP_LOAD   = 8'h8B;
   localparam logic [0:7] OP_MUL    = 8'hF7;
   localparam logic [0:7] OP_PUSH   = 8'hFF;

   // Record handed from execute to writeback; bit 0 is the MSB of every field.
   typedef struct packed {
      logic [0:63] alu_result;
      logic [0:63] alu_ext_result;
      logic [0:63] pc;
      logic [0:63] regB;
      logic [0:63] disp;
      logic [0:63] imm;
      logic [0:7]  opcode;
      logic [0:3]  regByte;
      logic [0:3]  rmByte;
      logic        sim_end;
   } EX_WB;

   typedef enum logic {EX_IDLE = 1'b0, EX_MUL = 1'b1} ex_state_t;

   // Single-cycle ALU result; unknown opcodes pass regA through.
   function automatic logic [0:63] alu_calc(input logic [0:7]  op,
                                            input logic [0:63] a,
                                            input logic [0:63] b,
                                            input logic [0:63] disp,
                                            input logic [0:63] imm);
      logic [0:63] r;
      case (op)
         OP_ADD:    r = a + b;
         OP_SUB:    r = b - a;
         OP_AND:    r = a & b;
         OP_OR:     r = a | b;
         OP_XOR:    r = a ^ b;
         OP_ALUIMM: r = b + imm;
         OP_STORE:  r = a + disp;
         OP_LOAD:   r = b;
         OP_PUSH:   r = a;
         default:   r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mod_mul_seq.sv
// 64x64->128 unsigned shift-add multiplier, one iteration per clock.
// done is combinational during the final iteration cycle and product then
// shows the completed result, so the consumer can capture it on that edge.
module mod_mul_seq
   import pipeline_pkg::*;
#(
   parameter int CYCLES = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [0:63]  a,
   input  logic [0:63]  b,
   output logic         done,
   output logic [0:127] product
);

   logic [63:0] a_q;
   logic [63:0] hi_q;
   logic [63:0] lo_q;
   logic [6:0]  cnt_q;
   logic        running_q;
   logic [64:0] sum;
   logic [63:0] hi_n;
   logic [63:0] lo_n;

   // One shift-add step: add multiplicand when the multiplier LSB is set, then shift right.
   always_comb begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : 65'd0);
      hi_n = sum[64:1];
      lo_n = {sum[0], lo_q[63:1]};
   end

   assign done    = running_q && (cnt_q == 7'(CYCLES - 1));
   assign product = {hi_n, lo_n};

   // Operand latch on start, then iterate until the final step completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
      end else if (start) begin
         a_q       <= a;
         hi_q      <= '0;
         lo_q      <= b;
         cnt_q     <= '0;
         running_q <= 1'b1;
      end else if (running_q) begin
         hi_q  <= hi_n;
         lo_q  <= lo_n;
         cnt_q <= cnt_q + 7'd1;
         if (done) running_q <= 1'b0;
      end
   end

endmodule

// File: rtl/mod_execute.sv
// Execute stage: single-entry EX_WB output register fed by a one-cycle ALU
// or by the sequential multiplier.
// Handshake: an instruction transfers on an edge where idex_valid && idex_ready;
// a record transfers to writeback on an edge where can_writeback && exwb_ready.
module mod_execute
   import pipeline_pkg::*;
#(
   parameter int MUL_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        idex_valid,
   output logic        idex_ready,
   input  logic [0:7]  idex_opcode,
   input  logic [0:63] idex_regA,
   input  logic [0:63] idex_regB,
   input  logic [0:63] idex_disp,
   input  logic [0:63] idex_imm,
   input  logic [0:63] idex_pc,
   input  logic [0:3]  idex_regByte,
   input  logic [0:3]  idex_rmByte,
   input  logic        idex_sim_end,
   input  logic        exwb_ready,
   output EX_WB        exwb,
   output logic        can_writeback,
   output logic        busy
);

   ex_state_t    state;
   EX_WB         pend;
   EX_WB         rec;
   logic         accept;
   logic         mul_start;
   logic         mul_done;
   logic [0:127] mul_product;

   assign idex_ready = reset && (state == EX_IDLE) && (!can_writeback || exwb_ready);
   assign accept     = idex_valid && idex_ready;
   assign mul_start  = accept && (idex_opcode == OP_MUL);
   assign busy       = (state == EX_MUL);

   // Record built from the incoming instruction with the single-cycle result.
   always_comb begin
      rec                = '0;
      rec.alu_result     = alu_calc(idex_opcode, idex_regA, idex_regB, idex_disp, idex_imm);
      rec.alu_ext_result = '0;
      rec.pc             = idex_pc;
      rec.regB           = idex_regB;
      rec.disp           = idex_disp;
      rec.imm            = idex_imm;
      rec.opcode         = idex_opcode;
      rec.regByte        = idex_regByte;
      rec.rmByte         = idex_rmByte;
      rec.sim_end        = idex_sim_end;
   end

   mod_mul_seq #(.CYCLES(MUL_CYCLES)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (idex_regA),
      .b       (idex_regB),
      .done    (mul_done),
      .product (mul_product)
   );

   // State machine and output slot: load, drain, or park a MUL record until done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= EX_IDLE;
         can_writeback <= 1'b0;
         exwb          <= '0;
         pend          <= '0;
      end else begin
         case (state)
            EX_IDLE: begin
               if (accept) begin
                  if (idex_opcode == OP_MUL) begin
                     // Slot is empty or draining on this edge; result arrives later.
                     pend          <= rec;
                     state         <= EX_MUL;
                     can_writeback <= 1'b0;
                  end else begin
                     exwb          <= rec;
                     can_writeback <= 1'b1;
                  end
               end else if (can_writeback && exwb_ready) begin
                  can_writeback <= 1'b0;
               end
            end
            EX_MUL: begin
               if (mul_done) begin
                  exwb                <= pend;
                  exwb.alu_result     <= mul_product[64:127];
                  exwb.alu_ext_result <= mul_product[0:63];
                  can_writeback       <= 1'b1;
                  state               <= EX_IDLE;
               end
            end
            default: state <= EX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_execute.sv
// Directed bench for mod_execute: vector table plus hand-written multi-cycle sequences.
module tb_mod_execute;
   import pipeline_pkg::*;

   logic        clk;
   logic        reset;
   logic        idex_valid;
   logic        idex_ready;
   logic [0:7]  idex_opcode;
   logic [0:63] idex_regA;
   logic [0:63] idex_regB;
   logic [0:63] idex_disp;
   logic [0:63] idex_imm;
   logic [0:63] idex_pc;
   logic [0:3]  idex_regByte;
   logic [0:3]  idex_rmByte;
   logic        idex_sim_end;
   logic        exwb_ready;
   EX_WB        exwb;
   logic        can_writeback;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [0:7]  op;
      logic [0:63] a;
      logic [0:63] b;
      logic [0:63] disp;
      logic [0:63] imm;
      logic [0:63] exp;
   } vec_t;

   vec_t vecs[13];

   mod_execute dut (
      .clk           (clk),
      .reset         (reset),
      .idex_valid    (idex_valid),
      .idex_ready    (idex_ready),
      .idex_opcode   (idex_opcode),
      .idex_regA     (idex_regA),
      .idex_regB     (idex_regB),
      .idex_disp     (idex_disp),
      .idex_imm      (idex_imm),
      .idex_pc       (idex_pc),
      .idex_regByte  (idex_regByte),
      .idex_rmByte   (idex_rmByte),
      .idex_sim_end  (idex_sim_end),
      .exwb_ready    (exwb_ready),
      .exwb          (exwb),
      .can_writeback (can_writeback),
      .busy          (busy)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [0:7] op, input logic [0:63] a, input logic [0:63] b,
                        input logic [0:63] disp, input logic [0:63] imm, input logic [0:63] pc,
                        input logic [0:3] rb, input logic [0:3] rm, input logic se);
      idex_valid   = 1'b1;
      idex_opcode  = op;
      idex_regA    = a;
      idex_regB    = b;
      idex_disp    = disp;
      idex_imm     = imm;
      idex_pc      = pc;
      idex_regByte = rb;
      idex_rmByte  = rm;
      idex_sim_end = se;
   endtask

   // Issue one MUL from a negedge and wait (bounded) for its record.
   task automatic run_mul(input logic [0:63] a, input logic [0:63] b,
                          input logic [0:63] exp_lo, input logic [0:63] exp_hi);
      int cyc;
      logic busy_ok;
      logic ready_ok;
      exwb_ready = 1'b1;
      drive(OP_MUL, a, b, 64'h0, 64'h0, 64'h7000, 4'h3, 4'h9, 1'b0);
      @(posedge clk);
      @(negedge clk);
      // Keep offering an ADD to confirm it is refused while the multiply runs.
      drive(OP_ADD, 64'h1, 64'h1, 64'h0, 64'h0, 64'h0, 4'h0, 4'h0, 1'b0);
      cyc = 0;
      busy_ok = 1'b1;
      ready_ok = 1'b1;
      while (!can_writeback && cyc < 80) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (idex_ready !== 1'b0) ready_ok = 1'b0;
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      idex_valid = 1'b0;
      chk("mul_busy_held", {127'd0, busy_ok}, 128'd1);
      chk("mul_ready_low", {127'd0, ready_ok}, 128'd1);
      chk("mul_latency", 128'(cyc), 128'd64);
      chk("mul_lo", exwb.alu_result, exp_lo);
      chk("mul_hi", exwb.alu_ext_result, exp_hi);
      chk("mul_pc", exwb.pc, 64'h7000);
      chk("mul_busy_clear", {127'd0, busy}, 128'd0);
      @(posedge clk);
      @(negedge clk);
      chk("mul_drained", {127'd0, can_writeback}, 128'd0);
   endtask

   initial begin
      logic [0:63] ones;
      EX_WB saved;
      logic no_rec;
      ones = {64{1'b1}};

      vecs[0]  = '{OP_ADD,    64'd3,      64'd4,      64'd0,     64'd0,    64'd7};
      vecs[1]  = '{OP_SUB,    64'd1,      64'd10,     64'd0,     64'd0,    64'd9};
      vecs[2]  = '{OP_XOR,    64'hFF,     64'h0F,     64'd0,     64'd0,    64'hF0};
      vecs[3]  = '{OP_AND,    64'hF0F0,   64'hFF00,   64'd0,     64'd0,    64'hF000};
      vecs[4]  = '{OP_OR,     64'h0F00,   64'h00F0,   64'd0,     64'd0,    64'h0FF0};
      vecs[5]  = '{OP_ALUIMM, 64'd9,      64'd100,    64'd0,     64'd23,   64'd123};
      vecs[6]  = '{OP_STORE,  64'h1000,   64'd5,      64'h10,    64'd0,    64'h1010};
      vecs[7]  = '{OP_LOAD,   64'd1,      64'h77,     64'd0,     64'd0,    64'h77};
      vecs[8]  = '{OP_PUSH,   64'h55,     64'h66,     64'd0,     64'd0,    64'h55};
      vecs[9]  = '{8'h42,     64'h99,     64'h11,     64'd0,     64'd0,    64'h99};
      vecs[10] = '{OP_ADD,    ones,       64'd1,      64'd0,     64'd0,    64'd0};
      vecs[11] = '{OP_SUB,    64'd1,      64'd0,      64'd0,     64'd0,    ones};
      vecs[12] = '{OP_ALUIMM, 64'd0,      64'd5,      64'd0,     ones,     64'd4};

      // reset state
      reset = 1'b0;
      exwb_ready = 1'b1;
      drive(OP_ADD, 64'd1, 64'd2, 64'd0, 64'd0, 64'd0, 4'd0, 4'd0, 1'b0);
      #12;
      chk("rst_canwb", {127'd0, can_writeback}, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_ready", {127'd0, idex_ready}, 128'd0);
      chk("rst_exwb_res", exwb.alu_result, 128'd0);
      chk("rst_exwb_pc", exwb.pc, 128'd0);
      @(negedge clk);
      reset = 1'b1;
      idex_valid = 1'b0;
      @(negedge clk);

      // back-to-back table with field propagation
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].disp, vecs[i].imm,
               64'h400 + 64'(i * 4), 4'(i), 4'(15 - i), (i == 12));
         #1;
         chk("tbl_ready", {127'd0, idex_ready}, 128'd1);
         @(posedge clk);
         @(negedge clk);
         chk("tbl_result", exwb.alu_result, vecs[i].exp);
         chk("tbl_ext", exwb.alu_ext_result, 128'd0);
         chk("tbl_canwb", {127'd0, can_writeback}, 128'd1);
         chk("tbl_pc", exwb.pc, 64'h400 + 64'(i * 4));
         chk("tbl_regByte", exwb.regByte, 128'(i));
         chk("tbl_rmByte", exwb.rmByte, 128'(15 - i));
         chk("tbl_sim_end", {127'd0, exwb.sim_end}, {127'd0, (i == 12)});
         chk("tbl_opcode", exwb.opcode, vecs[i].op);
         chk("tbl_disp", exwb.disp, vecs[i].disp);
      end
      idex_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("drain_after_table", {127'd0, can_writeback}, 128'd0);

      // backpressure
      drive(OP_ADD, 64'd5, 64'd6, 64'd0, 64'd0, 64'h500, 4'd1, 4'd2, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_first", exwb.alu_result, 64'd11);
      exwb_ready = 1'b0;
      drive(OP_SUB, 64'd2, 64'd20, 64'd0, 64'd0, 64'h504, 4'd3, 4'd4, 1'b0);
      saved = exwb;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_ready_low", {127'd0, idex_ready}, 128'd0);
         @(posedge clk);
         @(negedge clk);
         chk("bp_hold_res", exwb.alu_result, 64'd11);
         chk("bp_hold_pc", exwb.pc, 64'h500);
         chk("bp_hold_all", {127'd0, (exwb == saved)}, 128'd1);
         chk("bp_canwb", {127'd0, can_writeback}, 128'd1);
      end
      exwb_ready = 1'b1;
      #1;
      chk("bp_ready_back", {127'd0, idex_ready}, 128'd1);
      @(posedge clk);
      @(negedge clk);
      chk("bp_next", exwb.alu_result, 64'd18);
      chk("bp_next_canwb", {127'd0, can_writeback}, 128'd1);
      idex_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_drain", {127'd0, can_writeback}, 128'd0);

      // multiply with overflow into the high word
      run_mul(ones, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);

      // reset during MUL
      drive(OP_MUL, 64'd7, 64'd9, 64'd0, 64'd0, 64'h800, 4'd0, 4'd0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      idex_valid = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("mulrst_busy_before", {127'd0, busy}, 128'd1);
      reset = 1'b0;
      #1;
      chk("mulrst_busy", {127'd0, busy}, 128'd0);
      chk("mulrst_canwb", {127'd0, can_writeback}, 128'd0);
      chk("mulrst_exwb", exwb.alu_result, 128'd0);
      @(negedge clk);
      reset = 1'b1;
      no_rec = 1'b1;
      repeat (70) begin
         @(negedge clk);
         if (can_writeback !== 1'b0 || busy !== 1'b0) no_rec = 1'b0;
      end
      chk("mulrst_no_record", {127'd0, no_rec}, 128'd1);
      run_mul(64'd3, 64'd5, 64'd15, 64'd0);

      // reset mid-stream with a record pending
      drive(OP_ADD, 64'd1, 64'd1, 64'd0, 64'd0, 64'h900, 4'd0, 4'd0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      exwb_ready = 1'b0;
      idex_valid = 1'b0;
      chk("midrst_pending", {127'd0, can_writeback}, 128'd1);
      reset = 1'b0;
      #1;
      chk("midrst_canwb", {127'd0, can_writeback}, 128'd0);
      chk("midrst_exwb", exwb.alu_result, 128'd0);
      chk("midrst_pc", exwb.pc, 128'd0);
      chk("midrst_ready", {127'd0, idex_ready}, 128'd0);
      @(negedge clk);
      reset = 1'b1;
      exwb_ready = 1'b1;
      drive(OP_ADD, 64'd5, 64'd7, 64'd0, 64'd0, 64'hA00, 4'd0, 4'd0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("midrst_first_add", exwb.alu_result, 64'd12);
      chk("midrst_first_canwb", {127'd0, can_writeback}, 128'd1);
      idex_valid = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_execute.md
Name: mod_execute

Overview:
- Execute stage that produces the EX_WB pipeline record consumed by the writeback stage.
- Accepts decoded operands from ID/EX over a valid/ready handshake and computes the ALU result. 0xF7 MUL runs as a 64-cycle sequential operation.
- Holds the result in a single-entry output register and presents it to writeback via can_writeback, stalling under writeback backpressure.

Parameters:
- MUL_CYCLES, 64, iteration count of the sequential multiplier; equals the operand width.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- idex_valid  in  1  ID/EX presents an instruction
- idex_ready  out  1  execute accepts this cycle
- idex_opcode  in  [0:7]  primary opcode
- idex_regA  in  [0:63]  contents of reg-field register
- idex_regB  in  [0:63]  contents of rm-field register
- idex_disp  in  [0:63]  sign-extended displacement
- idex_imm  in  [0:63]  sign-extended immediate
- idex_pc  in  [0:63]  PC of next instruction
- idex_regByte  in  [0:3]  reg-field register index
- idex_rmByte  in  [0:3]  rm-field register index
- idex_sim_end  in  1  last instruction marker
- exwb_ready  in  1  writeback consumes exwb this cycle
- exwb  out  EX_WB  output record
- can_writeback  out  1  exwb holds a valid record
- busy  out  1  multiplier in progress

Behaviour:
- Bit order is [0:63] throughout; arithmetic is modulo 2^64, unsigned.
- Reset (async assert, sync-release use): state=IDLE; can_writeback=0; exwb all-zero; busy=0; idex_ready=0 while reset=0.
- Reset during MUL aborts the operation. No partial result ever appears.
- States: IDLE, MUL.
- idex_ready = (state==IDLE) && (!can_writeback || exwb_ready).
- Accept = idex_valid && idex_ready.
- Single-cycle ops, on an accept edge: load exwb and set can_writeback=1, visible the cycle after the edge (latency 1).
- Result per opcode:
  - 0x01 ADD: regA+regB
  - 0x29 SUB: regB-regA
  - 0x21 AND, 0x09 OR, 0x31 XOR: regA op regB
  - 0x81: regB+imm
  - 0x89 store: regA+disp, the effective address
  - 0x8B load: regB
  - 0xFF: regA, the pushed value
  - Any other opcode: regA (pass-through).
- For all single-cycle ops, alu_ext_result=0.
- Every record copies pc, regB, disp, imm, opcode, regByte, rmByte and sim_end into exwb unchanged.
- MUL (0xF7), on accept: latch operands into mod_mul_seq; state=MUL; busy=1.
  - If can_writeback was set and exwb_ready=0, accept is impossible by the idex_ready rule.
- In MUL, each cycle performs one shift-add iteration. After MUL_CYCLES iterations the done pulse triggers these updates on that edge:
  - exwb.alu_result = low 64 bits of regA*regB
  - exwb.alu_ext_result = high 64 bits
  - can_writeback=1, state=IDLE, busy=0
- MUL latency: record visible 64 cycles after the accept edge.
- Drain: can_writeback && exwb_ready clears can_writeback on the edge, unless a new accept on the same edge reloads it. Back-to-back single-cycle ops therefore sustain 1 per cycle.
- A MUL result landing on an edge where the prior record is still undrained cannot occur, because MUL acceptance requires the output slot to be free or draining.
- exwb is stable while can_writeback=1 && exwb_ready=0.
- exwb_ready while can_writeback=0 is ignored.
- Inputs are ignored when idex_valid=0 or idex_ready=0.

Decomposition:
- Shared package (e.g. pipeline_pkg):
  - EX_WB typedef, moved out of the writeback stage so both stages import one definition
  - opcode constants: OP_ADD=8'h01, OP_SUB=8'h29, OP_AND=8'h21, OP_OR=8'h09, OP_XOR=8'h31, OP_ALUIMM=8'h81, OP_STORE=8'h89, OP_LOAD=8'h8B, OP_MUL=8'hF7, OP_PUSH=8'hFF
- Sub-module mod_mul_seq: 64x64→128 unsigned shift-add multiplier.
  - Ports: clk, reset, start, a, b, done, product[0:127].
  - Contains a 7-bit iteration counter.

Test Plan:
- Reset mid-stream: reset=0 while can_writeback=1 → can_writeback=0 and exwb=0 immediately (async). After release, the first ADD regA=5, regB=7 → alu_result=12 one cycle later.
- Back-to-back single-cycle ops with exwb_ready=1: the sequence ADD(3,4), SUB(regA=1, regB=10), XOR(FF, 0F) → results 7, 9, F0 on consecutive cycles; idex_ready stays 1.
- Backpressure: exwb_ready=0 for 5 cycles after the ADD result → exwb is held constant and idex_ready=0. When exwb_ready=1, the next instruction is accepted on the same edge.
- MUL: regA=FFFF_FFFF_FFFF_FFFF, regB=2 → after 64 cycles, alu_result=FFFF_FFFF_FFFF_FFFE and alu_ext_result=1. busy=1 and idex_ready=0 throughout.
- Wrap and fields: ADD FFFF_FFFF_FFFF_FFFF+1 → alu_result=0. A STORE with regA=1000, disp=10 → alu_result=1010. regByte, rmByte, pc and sim_end are propagated unchanged.
- Reset during MUL at iteration 30 → no record appears. After release, MUL(3,5) → alu_result=15, alu_ext_result=0.
